// File: rtl/digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub
//   Digit-serial adder/subtractor. Operands are accepted through a
//   valid/ready handshake, processed DIGIT bits per clock (LSB digit first)
//   with a registered carry between digits, and the WIDTH-bit result plus
//   carry-out and signed-overflow flag are returned through a second
//   valid/ready handshake.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one digit per clock, N = WIDTH/DIGIT cycles
//   DONE  | result held, out_valid=1 until out_ready
//
// Ports
//   clk        in   rising-edge clock
//   aclr       in   asynchronous active-high reset
//   flush      in   synchronous abort, returns to IDLE
//   in_valid   in   operand strobe
//   in_ready   out  operands accepted (IDLE only)
//   sub        in   0: a+b, 1: a-b
//   a, b       in   WIDTH-bit operands
//   out_valid  out  result available (DONE only)
//   out_ready  in   consumer takes result
//   sum        out  low WIDTH bits of the result
//   cout       out  carry out of MSB (sub: 1 = no borrow)
//   ovf        out  signed overflow
// ---------------------------------------------------------------------------
module digit_serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT:0]   dsum;
    logic             c_msb;
    logic [WIDTH-1:0] res_next;
    logic             last;

    always_comb begin
        dsum     = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};
        // Carry into the digit's top bit, recovered from its sum bit; on the
        // last digit this is the carry into bit WIDTH-1.
        c_msb    = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum[DIGIT-1];
        // New digit enters at the MSB end, earlier digits move down.
        res_next = (res_sh >> DIGIT)
                 | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last     = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state  <= S_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            res_sh <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        // Subtraction as a + ~b + 1: invert b, seed carry.
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    op_a   <= op_a >> DIGIT;
                    op_b   <= op_b >> DIGIT;
                    res_sh <= res_next;
                    carry  <= dsum[DIGIT];
                    if (last) begin
                        sum_q  <= res_next;
                        cout_q <= dsum[DIGIT];
                        ovf_q  <= c_msb ^ dsum[DIGIT];
                        cnt    <= '0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Testbench for digit_serial_addsub: three WIDTH=8 instances with
// DIGIT = 4, 1 and 8, directed vectors plus hand-written corner sequences
// and a randomised run against a 9-bit arithmetic reference.
module tb_digit_serial_addsub;

    localparam int NDUT = 3;

    logic       clk;
    logic       aclr;
    logic       flush;
    logic       in_valid  [NDUT];
    logic       in_ready  [NDUT];
    logic       sub       [NDUT];
    logic [7:0] a         [NDUT];
    logic [7:0] b         [NDUT];
    logic       out_valid [NDUT];
    logic       out_ready [NDUT];
    logic [7:0] sum       [NDUT];
    logic       cout      [NDUT];
    logic       ovf       [NDUT];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : 8;
        digit_serial_addsub #(.WIDTH(8), .DIGIT(DG)) dut (
            .clk       (clk),
            .aclr      (aclr),
            .flush     (flush),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .sub       (sub[g]),
            .a         (a[g]),
            .b         (b[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .sum       (sum[g]),
            .cout      (cout[g]),
            .ovf       (ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];
    int   exp_lat [NDUT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: full 9-bit add of a and (possibly inverted) b plus carry-in.
    task automatic model(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         output logic [7:0] s, output logic c, output logic o);
        logic [8:0] t;
        logic [7:0] bb;
        bb = sv ? ~bv : bv;
        t  = {1'b0, av} + {1'b0, bb} + {8'd0, sv};
        s  = t[7:0];
        c  = t[8];
        o  = (av[7] == bb[7]) && (s[7] != av[7]);
    endtask

    task automatic do_op(input int d, input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         output logic [7:0] s, output logic c, output logic o, output int lat);
        @(negedge clk);
        a[d] = av; b[d] = bv; sub[d] = sv; in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        a[d] = 8'h00; b[d] = 8'h00; sub[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s = sum[d]; c = cout[d]; o = ovf[d];
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] s, es;
        logic       c, o, ec, eo;
        int         lat;
        logic       seen;
        logic [7:0] q_s [$];
        logic       q_c [$];
        logic       q_o [$];
        int         done_ops, cyc;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[6] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
        exp_lat[0] = 2; exp_lat[1] = 8; exp_lat[2] = 1;

        aclr = 1'b1; flush = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0; sub[d] = 1'b0;
            a[d] = 8'h00; b[d] = 8'h00;
        end

        // Reset state
        #12;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_sum%0d", d), sum[d], 8'h00);
            check($sformatf("rst_cout%0d", d), cout[d], 1'b0);
            check($sformatf("rst_ovf%0d", d), ovf[d], 1'b0);
            check($sformatf("rst_ov%0d", d), out_valid[d], 1'b0);
        end
        @(negedge clk);
        aclr = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("rst_ir%0d", d), in_ready[d], 1'b1);

        // Directed vectors on every digit size
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 8; i++) begin
                do_op(d, vecs[i].a, vecs[i].b, vecs[i].sub, s, c, o, lat);
                check($sformatf("vec%0d_d%0d_sum", i, d), s, vecs[i].sum);
                check($sformatf("vec%0d_d%0d_cout", i, d), c, vecs[i].cout);
                check($sformatf("vec%0d_d%0d_ovf", i, d), o, vecs[i].ovf);
                check($sformatf("vec%0d_d%0d_lat", i, d), lat, exp_lat[d]);
            end
        end

        // Backpressure: result held, no second accept while in_valid stays high
        @(negedge clk);
        a[0] = 8'h7F; b[0] = 8'h01; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        a[0] = 8'h55; b[0] = 8'h55;
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", lat, 2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_ov%0d", k), out_valid[0], 1'b1);
            check($sformatf("bp_ir%0d", k), in_ready[0], 1'b0);
            check($sformatf("bp_res%0d", k), {sum[0], cout[0], ovf[0]}, {8'h80, 1'b0, 1'b1});
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("bp_exit_ov", out_valid[0], 1'b0);
        check("bp_exit_ir", in_ready[0], 1'b1);
        check("bp_hold_sum", sum[0], 8'h80);

        // Flush after digit 0 of 0x12+0x34
        @(negedge clk);
        a[0] = 8'h12; b[0] = 8'h34; sub[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_ov", out_valid[0], 1'b0);
        check("fl_ir", in_ready[0], 1'b1);
        check("fl_sum_kept", sum[0], 8'h80);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid[0];
        end
        check("fl_no_ov", seen, 1'b0);
        do_op(0, 8'h01, 8'h01, 1'b0, s, c, o, lat);
        check("fl_next_sum", s, 8'h02);
        check("fl_next_flags", {c, o}, 2'b00);

        // Flush beats accept in the same cycle
        @(negedge clk);
        a[0] = 8'h11; b[0] = 8'h22; in_valid[0] = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0; flush = 1'b0;
        check("fl_prio_ir", in_ready[0], 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid[0];
        end
        check("fl_prio_no_ov", seen, 1'b0);

        // aclr mid-RUN on the bit-serial instance (previous result 0x80, ovf=1)
        check("pre_aclr_ovf", ovf[1], 1'b1);
        @(negedge clk);
        a[1] = 8'hA5; b[1] = 8'h5A; sub[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        aclr = 1'b1;
        #1;
        check("aclr_sum", sum[1], 8'h00);
        check("aclr_flags", {cout[1], ovf[1]}, 2'b00);
        check("aclr_ov", out_valid[1], 1'b0);
        @(negedge clk);
        aclr = 1'b0;
        #1;
        check("aclr_ir", in_ready[1], 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid[1];
        end
        check("aclr_no_ov", seen, 1'b0);

        // Random handshakes against the reference
        for (int d = 0; d < NDUT; d++) begin
            int target;
            target = (d == 0) ? 1000 : 200;
            done_ops = 0; cyc = 0;
            q_s.delete(); q_c.delete(); q_o.delete();
            while (done_ops < target && cyc < 30000) begin
                @(posedge clk);
                #1;
                cyc++;
                in_valid[d]  = 1'($urandom_range(0, 1));
                out_ready[d] = 1'($urandom_range(0, 1));
                a[d]         = 8'($urandom);
                b[d]         = 8'($urandom);
                sub[d]       = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (in_valid[d] && in_ready[d]) begin
                    model(a[d], b[d], sub[d], es, ec, eo);
                    q_s.push_back(es); q_c.push_back(ec); q_o.push_back(eo);
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (q_s.size() == 0) begin
                        check($sformatf("rnd_d%0d_spurious", d), 1, 0);
                    end else begin
                        es = q_s.pop_front(); ec = q_c.pop_front(); eo = q_o.pop_front();
                        check($sformatf("rnd_d%0d_op%0d", d, done_ops),
                              {sum[d], cout[d], ovf[d]}, {es, ec, eo});
                    end
                    done_ops++;
                end
            end
            check($sformatf("rnd_d%0d_completed", d), done_ops, target);
            @(posedge clk);
            #1;
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
            repeat (12) @(posedge clk);
            #1;
            out_ready[d] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
